pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Consumer side of the PLL `locked` interface.
- Drives the PLL `rst` input and watches `locked` from the PLL.
- Releases the system reset for the 23.75 MHz / 1 MHz ECG datapath only after lock has been stable for a set time.
- Retries a PLL that fails to lock, latches a fault after repeated failures, and counts lock-loss events during operation.
- Sits at top level, clocked by the 50 MHz board reference clock, which is the same clock that feeds the PLL `refclk`.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on pll_locked (minimum 2).
- PLL_RST_CYCLES, 16, cycles pll_rst is held high per reset pulse.
- LOCK_TIMEOUT, 50000, cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz).
- STABLE_CYCLES, 1024, consecutive cycles synchronized lock must stay high before release.
- MAX_RETRY, 3, number of retries allowed after the initial attempt before FAULT.
- LOSS_CNT_W, 8, width of the lock-loss event counter.

Ports:
- clk  input  1  50 MHz reference clock; the only clock in the block.
- rst_n  input  1  asynchronous active-low reset.
- pll_locked  input  1  PLL `locked`; asynchronous to clk.
- clear_fault  input  1  synchronous one-cycle pulse; restarts the sequence from FAULT.
- pll_rst  output  1  active-high reset to the PLL `rst`.
- sys_rst_n  output  1  active-low system reset for the downstream datapath.
- pll_ready  output  1  high while in RUN.
- fault  output  1  high while in FAULT.
- retry_cnt  output  4  retries used in the current lock attempt.
- loss_cnt  output  LOSS_CNT_W  saturating count of lock losses seen in RUN.

Behaviour:
- Reset values (rst_n low, applied asynchronously):
  - Outputs: pll_rst=1, sys_rst_n=0, pll_ready=0, fault=0, retry_cnt=0, loss_cnt=0.
  - Internal: state=PLL_RESET, timers=0, synchronizer=0.
- All outputs are registered. Outputs are decoded from the state register, so they change on the clock edge on which the state changes.
- pll_locked passes through SYNC_STAGES flops to give locked_s. Only locked_s is used internally.
- PLL_RESET:
  - pll_rst=1, sys_rst_n=0.
  - The timer counts PLL_RST_CYCLES cycles, then the block moves to WAIT_LOCK with the timer cleared.
- WAIT_LOCK:
  - pll_rst=0, sys_rst_n=0.
  - If locked_s=1, move to STABLE and clear the timer. This check takes priority over the timeout.
  - If the timer reaches LOCK_TIMEOUT-1 with retry_cnt<MAX_RETRY, increment retry_cnt and move to PLL_RESET.
  - If the timer reaches LOCK_TIMEOUT-1 with retry_cnt==MAX_RETRY, move to FAULT.
- STABLE:
  - The timer counts consecutive cycles with locked_s=1.
  - If locked_s=0, return to WAIT_LOCK with the timer cleared. retry_cnt is not incremented; the timeout restarts.
  - When the count reaches STABLE_CYCLES, move to RUN.
- RUN:
  - sys_rst_n=1, pll_ready=1, retry_cnt cleared.
  - If locked_s=0, move to WAIT_LOCK. On that edge sys_rst_n goes to 0 and pll_ready goes to 0, and loss_cnt increments.
  - loss_cnt saturates at all-ones and never wraps.
- FAULT:
  - pll_rst=1, sys_rst_n=0, fault=1.
  - clear_fault=1 moves to PLL_RESET with retry_cnt=0 and fault=0 on the next edge.
  - clear_fault is ignored in every other state.
- loss_cnt clears only on rst_n.
- Latency:
  - pll_locked rising edge to sys_rst_n rising edge is exactly SYNC_STAGES+STABLE_CYCLES+1 clk cycles, assuming lock stays high.
  - pll_locked falling edge while in RUN to sys_rst_n falling edge is exactly SYNC_STAGES+1 cycles.
- Simultaneous events: in WAIT_LOCK, a lock arriving on the timeout cycle goes to STABLE and no retry is counted.
- Reset mid-operation: asserting rst_n low in any state forces all reset values immediately, and the sequence restarts from PLL_RESET.
- Glitch handling: a pll_locked pulse shorter than one clk may be missed. This is acceptable because STABLE filters it.

Test Plan:
Simulation parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2, LOSS_CNT_W=2.
- Reset release, pll_locked=0 -> pll_rst=1 for 4 cycles then 0; sys_rst_n=0, fault=0.
- pll_locked rises 3 cycles after pll_rst falls and stays high -> sys_rst_n and pll_ready rise exactly 11 cycles after that edge; retry_cnt=0.
- pll_locked drops for 3 cycles at STABLE count 5, then returns -> the block re-enters WAIT_LOCK with no retry counted, and sys_rst_n rises 11 cycles after the return.
- pll_locked held 0 -> three pll_rst pulses of 4 cycles, with retry_cnt stepping 0->1->2, then fault=1 after the third 20-cycle timeout. clear_fault pulse -> fault=0, pll_rst pulse, retry_cnt=0.
- In RUN, pll_locked falls -> sys_rst_n=0 after 3 cycles and loss_cnt=1; re-lock returns to RUN. Five loss events in total -> loss_cnt=3 (saturated).
- rst_n pulsed low while in STABLE -> outputs immediately take their reset values, and the full sequence repeats.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// Purpose : sequences PLL reset/lock and gates the ECG datapath system reset on stable lock.
// Latency : pll_locked rise -> sys_rst_n rise = SYNC_STAGES+STABLE_CYCLES+1; lock loss -> sys_rst_n fall = SYNC_STAGES+1.
// Backpressure: none; clear_fault is a one-cycle pulse honoured only in FAULT.
//
// Ports:
//   clk          50 MHz board reference (also feeds PLL refclk); only clock in the block
//   rst_n        asynchronous active-low reset
//   pll_locked   PLL locked flag, asynchronous to clk
//   clear_fault  one-cycle pulse, restarts the sequence from FAULT
//   pll_rst      active-high reset to the PLL
//   sys_rst_n    active-low reset for the downstream datapath
//   pll_ready    high while running on a stable lock
//   fault        high while latched in FAULT
//   retry_cnt    retries used in the current lock attempt
//   loss_cnt     saturating count of lock losses seen while running
module pll_lock_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRY      = 3,
  parameter int LOSS_CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  clear_fault,
  output logic                  pll_rst,
  output logic                  sys_rst_n,
  output logic                  pll_ready,
  output logic                  fault,
  output logic [3:0]            retry_cnt,
  output logic [LOSS_CNT_W-1:0] loss_cnt
);

  // One shared timer serves every timed state, so size it for the longest interval.
  localparam int TMAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int TMAX   = (TMAX_A > STABLE_CYCLES) ? TMAX_A : STABLE_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [2:0] S_PLL_RESET = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  logic [2:0]             state, state_nxt;
  logic [TW-1:0]          timer, timer_nxt;
  logic [3:0]             retry_nxt;
  logic                   loss_inc;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  // pll_locked comes from the PLL's own clock domain; only the synchronised copy is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    retry_nxt = retry_cnt;
    loss_inc  = 1'b0;
    case (state)
      S_PLL_RESET: begin
        if (timer == TW'(PLL_RST_CYCLES - 1)) begin
          state_nxt = S_WAIT_LOCK;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      S_WAIT_LOCK: begin
        // A lock seen on the timeout cycle wins: no retry is charged.
        if (locked_s) begin
          state_nxt = S_STABLE;
          timer_nxt = '0;
        end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
          timer_nxt = '0;
          if (retry_cnt < 4'(MAX_RETRY)) begin
            retry_nxt = retry_cnt + 4'd1;
            state_nxt = S_PLL_RESET;
          end else begin
            state_nxt = S_FAULT;
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      S_STABLE: begin
        // Any dropout restarts the lock wait without counting a retry.
        if (!locked_s) begin
          state_nxt = S_WAIT_LOCK;
          timer_nxt = '0;
        end else if (timer == TW'(STABLE_CYCLES - 1)) begin
          state_nxt = S_RUN;
          timer_nxt = '0;
          retry_nxt = 4'd0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      S_RUN: begin
        retry_nxt = 4'd0;
        if (!locked_s) begin
          state_nxt = S_WAIT_LOCK;
          timer_nxt = '0;
          loss_inc  = 1'b1;
        end
      end
      S_FAULT: begin
        if (clear_fault) begin
          state_nxt = S_PLL_RESET;
          timer_nxt = '0;
          retry_nxt = 4'd0;
        end
      end
      default: begin
        state_nxt = S_PLL_RESET;
        timer_nxt = '0;
        retry_nxt = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PLL_RESET;
      timer     <= '0;
      retry_cnt <= 4'd0;
      loss_cnt  <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      pll_ready <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      retry_cnt <= retry_nxt;
      if (loss_inc && (loss_cnt != {LOSS_CNT_W{1'b1}})) begin
        loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
      end
      pll_rst   <= (state_nxt == S_PLL_RESET) || (state_nxt == S_FAULT);
      sys_rst_n <= (state_nxt == S_RUN);
      pll_ready <= (state_nxt == S_RUN);
      fault     <= (state_nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Purpose : directed self-checking bench for pll_lock_sequencer with small timing parameters.
// Latency : expectations are counted in clk edges from each stimulus change.
// Backpressure: none.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       clear_fault;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       pll_ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [1:0] loss_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRY     (2),
    .LOSS_CNT_W    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .clear_fault(clear_fault),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .pll_ready  (pll_ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Advance n rising edges, landing 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    pll_locked  = 1'b0;
    clear_fault = 1'b0;
    tick(3);
    check("rst_pll_rst",   pll_rst,   1);
    check("rst_sys_rst_n", sys_rst_n, 0);
    check("rst_pll_ready", pll_ready, 0);
    check("rst_fault",     fault,     0);
    check("rst_retry",     retry_cnt, 0);
    check("rst_loss",      loss_cnt,  0);

    // Reset release: pll_rst held for 4 cycles.
    rst_n = 1'b1;
    tick(3);
    check("prst_hold",  pll_rst, 1);
    tick(1);
    check("prst_fall",  pll_rst, 0);
    check("prst_sys",   sys_rst_n, 0);
    check("prst_fault", fault, 0);

    // Lock 3 cycles after pll_rst falls: release 11 cycles later.
    tick(3);
    pll_locked = 1'b1;
    tick(10);
    check("lock_early", sys_rst_n, 0);
    tick(1);
    check("lock_sys",   sys_rst_n, 1);
    check("lock_ready", pll_ready, 1);
    check("lock_retry", retry_cnt, 0);

    // First loss in RUN: sys_rst_n falls 3 cycles after the drop.
    pll_locked = 1'b0;
    tick(2);
    check("loss1_early", sys_rst_n, 1);
    tick(1);
    check("loss1_sys",   sys_rst_n, 0);
    check("loss1_ready", pll_ready, 0);
    check("loss1_cnt",   loss_cnt,  1);

    // Relock, then drop for 3 cycles once the STABLE count has reached 5.
    pll_locked = 1'b1;
    tick(8);
    pll_locked = 1'b0;
    tick(3);
    check("glitch_sys",   sys_rst_n, 0);
    check("glitch_retry", retry_cnt, 0);
    pll_locked = 1'b1;
    tick(10);
    check("glitch_early", sys_rst_n, 0);
    check("glitch_retry2", retry_cnt, 0);
    tick(1);
    check("glitch_sys_up", sys_rst_n, 1);

    // Four more loss events; the 2-bit counter saturates at 3.
    for (int i = 2; i <= 5; i++) begin
      pll_locked = 1'b0;
      tick(3);
      check("lossN_sys", sys_rst_n, 0);
      check("lossN_cnt", loss_cnt, (i > 3) ? 3 : i);
      pll_locked = 1'b1;
      tick(11);
      check("lossN_relock", sys_rst_n, 1);
    end

    // Drive into STABLE, then pulse rst_n: values change without a clock edge.
    pll_locked = 1'b0;
    tick(3);
    pll_locked = 1'b1;
    tick(5);
    check("stbl_sys",  sys_rst_n, 0);
    check("stbl_loss", loss_cnt,  3);
    rst_n = 1'b0;
    pll_locked = 1'b0;
    #1;
    check("arst_pll_rst", pll_rst,   1);
    check("arst_sys",     sys_rst_n, 0);
    check("arst_loss",    loss_cnt,  0);
    check("arst_retry",   retry_cnt, 0);
    tick(2);
    rst_n = 1'b1;

    // No lock: three pll_rst pulses, retries 0->1->2, then FAULT.
    tick(4);
    check("r0_prst", pll_rst, 0);
    tick(19);
    check("r0_wait", pll_rst, 0);
    check("r0_cnt",  retry_cnt, 0);
    tick(1);
    check("r1_prst", pll_rst, 1);
    check("r1_cnt",  retry_cnt, 1);
    tick(3);
    check("r1_hold", pll_rst, 1);
    tick(1);
    check("r1_fall", pll_rst, 0);
    tick(19);
    check("r1_nofault", fault, 0);
    tick(1);
    check("r2_prst", pll_rst, 1);
    check("r2_cnt",  retry_cnt, 2);
    tick(4);
    check("r2_fall", pll_rst, 0);
    tick(19);
    check("r2_nofault", fault, 0);
    tick(1);
    check("flt_fault", fault, 1);
    check("flt_prst",  pll_rst, 1);
    check("flt_cnt",   retry_cnt, 2);
    tick(5);
    check("flt_latched", fault, 1);

    // Clear the fault: fresh pll_rst pulse with retry_cnt back at 0.
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    check("clr_fault", fault, 0);
    check("clr_prst",  pll_rst, 1);
    check("clr_cnt",   retry_cnt, 0);
    tick(4);
    check("clr_fall",  pll_rst, 0);

    // Lock lands on the timeout cycle: goes to STABLE, no retry.
    tick(17);
    pll_locked = 1'b1;
    tick(3);
    check("tmo_prst", pll_rst, 0);
    check("tmo_cnt",  retry_cnt, 0);
    tick(7);
    check("tmo_early", sys_rst_n, 0);
    tick(1);
    check("tmo_sys",   sys_rst_n, 1);
    check("tmo_ready", pll_ready, 1);
    check("tmo_loss",  loss_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
